// File: rtl/mem_stage.sv
// MEM stage: drives data-memory requests for loads/stores and registers the MEM/WB result.
// 1 cycle for ALU ops and zero-wait accesses, N+1 for N wait cycles; MemStallOut freezes upstream while waiting.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUOutIn,
  input  logic [31:0] RdDataBIn,
  input  logic [4:0]  RTIn,
  input  logic [4:0]  RDIn,
  input  logic        IsDstRtIn,
  input  logic        RdWrEnableIn,
  input  logic        IsLoadInsnIn,
  input  logic        IsStoreInsnIn,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [31:0] DMemWData,
  input  logic        DMemAck,
  input  logic [31:0] DMemRData,
  output logic        MemStallOut,
  output logic [31:0] WBDataOut,
  output logic [4:0]  WBRegOut,
  output logic        WBWrEnableOut,
  output logic        MisalignOut
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t      state;
  logic [31:0] addrQ;
  logic [31:0] wDataQ;
  logic        weQ;
  logic        wrEnQ;
  logic [4:0]  dstQ;

  logic [4:0]  dst;
  logic        isMem;
  logic        isStore;
  logic        aligned;
  logic        reqIdle;

  // Load wins when both class bits are set.
  assign dst     = IsDstRtIn ? RTIn : RDIn;
  assign isMem   = IsLoadInsnIn | IsStoreInsnIn;
  assign isStore = IsStoreInsnIn & ~IsLoadInsnIn;
  assign aligned = (ALUOutIn[1:0] == 2'b00);
  assign reqIdle = isMem & aligned;

  // Request is combinational so a zero-wait memory completes in the issuing cycle.
  always_comb begin
    DMemReq     = 1'b0;
    DMemWe      = 1'b0;
    DMemAddr    = 32'h0;
    DMemWData   = 32'h0;
    MemStallOut = 1'b0;
    if (rst) begin
      if (state == WAIT) begin
        DMemReq     = 1'b1;
        DMemWe      = weQ;
        DMemAddr    = addrQ;
        DMemWData   = wDataQ;
        MemStallOut = ~DMemAck;
      end else if (reqIdle) begin
        DMemReq     = 1'b1;
        DMemWe      = isStore;
        DMemAddr    = ALUOutIn;
        DMemWData   = RdDataBIn;
        MemStallOut = ~DMemAck;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      addrQ         <= 32'h0;
      wDataQ        <= 32'h0;
      weQ           <= 1'b0;
      wrEnQ         <= 1'b0;
      dstQ          <= 5'd0;
      WBDataOut     <= 32'h0;
      WBRegOut      <= 5'd0;
      WBWrEnableOut <= 1'b0;
      MisalignOut   <= 1'b0;
    end else begin
      MisalignOut <= 1'b0;
      case (state)
        IDLE: begin
          if (isMem && !aligned) begin
            MisalignOut   <= 1'b1;
            WBDataOut     <= ALUOutIn;
            WBRegOut      <= dst;
            WBWrEnableOut <= 1'b0;
          end else if (isMem) begin
            if (DMemAck) begin
              WBDataOut     <= isStore ? ALUOutIn : DMemRData;
              WBRegOut      <= dst;
              WBWrEnableOut <= isStore ? 1'b0 : RdWrEnableIn;
            end else begin
              // Stall edge: bubble into WB, capture the request for the wait.
              state         <= WAIT;
              addrQ         <= ALUOutIn;
              wDataQ        <= RdDataBIn;
              weQ           <= isStore;
              wrEnQ         <= RdWrEnableIn;
              dstQ          <= dst;
              WBWrEnableOut <= 1'b0;
            end
          end else begin
            WBDataOut     <= ALUOutIn;
            WBRegOut      <= dst;
            WBWrEnableOut <= RdWrEnableIn;
          end
        end
        WAIT: begin
          if (DMemAck) begin
            state         <= IDLE;
            WBDataOut     <= weQ ? addrQ : DMemRData;
            WBRegOut      <= dstQ;
            WBWrEnableOut <= weQ ? 1'b0 : wrEnQ;
          end else begin
            WBWrEnableOut <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
